// File: rtl/psum_collector_pkg.sv
// rtl/psum_collector_pkg.sv - shared types and width helpers for psum_collector
package psum_collector_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  // Position of a beat within its group, carried alongside the S1 sum.
  typedef struct packed {
    logic first;
    logic last;
  } beat_tag_t;

  function automatic int calc_psum_w(input int in_size_0, input int in_size_1);
    return in_size_0 + in_size_1 + 8;
  endfunction

  function automatic int calc_acc_w(input int psum_w, input int max_beats);
    return psum_w + 1 + $clog2(max_beats);
  endfunction

endpackage

// File: rtl/psum_collector_result_fifo.sv
// rtl/psum_collector_result_fifo.sv - 2-entry result FIFO; push and pop may coincide at any fill level
module result_fifo #(
  parameter int W = 25
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - adds redundant partial-sum pairs, accumulates beats into groups, queues results
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int PSUM_W    = calc_psum_w(IN_SIZE_0, IN_SIZE_1),
  parameter int MAX_BEATS = 16,
  parameter int LEN_W     = $clog2(MAX_BEATS) + 1,
  parameter int ACC_W     = calc_acc_w(PSUM_W, MAX_BEATS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [LEN_W-1:0]       cfg_len_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [1:0][PSUM_W-1:0] in_psum_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ACC_W-1:0]       out_data_o,
  output logic                   busy_o
);

  typedef struct packed {
    logic signed [PSUM_W:0] sum;
    beat_tag_t              tag;
  } s1_beat_t;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] eff_len;
  beat_tag_t        beat_tag;

  s1_beat_t         s1_q, s1_d;
  logic             s1_valid_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum_ext;
  logic             s2_last_q;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             fifo_full, fifo_empty, pop_eff;
  logic [1:0]       fifo_count;
  logic [2:0]       count_d, reserved_d;

  assign accept  = in_valid_i && in_ready_q;
  assign eff_len = (cfg_len_i == '0) ? LEN_W'(1) : cfg_len_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Length is latched on the first beat so later cfg_len_i changes cannot reshape the group.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (accept) begin
      if (state_q == IDLE) begin
        len_d = eff_len;
        cnt_d = LEN_W'(1);
        if (eff_len != LEN_W'(1)) state_d = ACC;
      end else begin
        cnt_d = cnt_q + LEN_W'(1);
        if ((cnt_q + LEN_W'(1)) == len_q) state_d = IDLE;
      end
    end
  end

  always_comb begin
    beat_tag.first = (state_q == IDLE);
    beat_tag.last  = (state_q == IDLE) ? (eff_len == LEN_W'(1))
                                       : ((cnt_q + LEN_W'(1)) == len_q);
  end

  always_comb begin
    s1_d.sum = {in_psum_i[0][PSUM_W-1], in_psum_i[0]} + {in_psum_i[1][PSUM_W-1], in_psum_i[1]};
    s1_d.tag = beat_tag;
  end

  assign sum_ext = {{(ACC_W-PSUM_W-1){s1_q.sum[PSUM_W]}}, s1_q.sum};

  // A last beat reserves a FIFO slot from acceptance until its push, so overflow is impossible.
  assign pop_eff    = out_ready_i && !fifo_empty;
  assign count_d    = {1'b0, fifo_count} + {2'b0, s2_last_q} - {2'b0, pop_eff};
  assign reserved_d = count_d + {2'b0, accept && beat_tag.last}
                              + {2'b0, s1_valid_q && s1_q.tag.last};
  assign in_ready_d = (reserved_d < 3'd2) && !(fifo_full && !pop_eff);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      acc_q      <= '0;
      s2_last_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      s1_valid_q <= accept;
      if (accept) s1_q <= s1_d;
      if (s1_valid_q) acc_q <= s1_q.tag.first ? sum_ext : acc_q + sum_ext;
      s2_last_q  <= s1_valid_q && s1_q.tag.last;
      in_ready_q <= in_ready_d;
    end
  end

  result_fifo #(
    .W (ACC_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (s2_last_q),
    .push_data_i (acc_q),
    .pop_i       (out_ready_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (out_data_o)
  );

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = !fifo_empty;
  assign busy_o      = (state_q == ACC) || s1_valid_q;

endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - directed and randomized checks of psum_collector
module tb_psum_collector;

  localparam int PSUM_W = 20;
  localparam int LEN_W  = 5;
  localparam int ACC_W  = 25;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [LEN_W-1:0]       cfg_len_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [1:0][PSUM_W-1:0] in_psum_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [ACC_W-1:0]       out_data_o;
  logic                   busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  psum_collector dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_len_i   (cfg_len_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_psum_i   (in_psum_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic set_beat(input int p0, input int p1, input int len);
    cfg_len_i    = len[LEN_W-1:0];
    in_psum_i[0] = p0[PSUM_W-1:0];
    in_psum_i[1] = p1[PSUM_W-1:0];
  endtask

  task automatic send_beat(input int p0, input int p1, input int len);
    int waited = 0;
    set_beat(p0, p1, len);
    in_valid_i = 1'b1;
    while (!in_ready_o && waited < 200) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (!in_ready_o) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_beat_timeout: in_ready_o=%0b required 1", in_ready_o);
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic pop_result(output logic [ACC_W-1:0] data, output bit ok);
    int waited = 0;
    while (!out_valid_o && waited < 100) begin
      @(posedge clk_i); #1;
      waited++;
    end
    ok   = out_valid_o;
    data = out_data_o;
    if (ok) begin
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      out_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    set_beat(0, 0, 1);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
    tests_run++;
    if (in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b required 1", in_ready_o); end
    tests_run++;
    if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b required 0", out_valid_o); end
    tests_run++;
    if (out_data_o !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %0d required 0", out_data_o); end
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b required 0", busy_o); end
  endtask

  task automatic test_len1_latency();
    logic [ACC_W-1:0] exp = ACC_W'(70);
    out_ready_i = 1'b1;
    set_beat(100, -30, 1);
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    tests_run++;
    if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL len1_valid_e0: got %0b required 0", out_valid_o); end
    @(posedge clk_i); #1;
    tests_run++;
    if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL len1_valid_e1: got %0b required 0", out_valid_o); end
    @(posedge clk_i); #1;
    tests_run++;
    if (out_valid_o !== 1'b1 || out_data_o !== exp) begin
      tests_failed++;
      $display("FAIL len1_result_e2: got valid=%0b data=%0d required valid=1 data=%0d", out_valid_o, $signed(out_data_o), $signed(exp));
    end
    @(posedge clk_i); #1;
    tests_run++;
    if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL len1_popped: got valid=%0b required 0", out_valid_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_len16_back_to_back();
    logic [ACC_W-1:0] data;
    logic [ACC_W-1:0] exp_a = ACC_W'(131072);
    logic [ACC_W-1:0] exp_b = ACC_W'(-131184);
    bit ok;
    for (int i = 0; i < 16; i++) send_beat(8192, 0, 16);
    tests_run++;
    if (in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_no_bubble: in_ready=%0b required 1", in_ready_o); end
    for (int i = 0; i < 16; i++) send_beat(-8192, -7, (i == 0) ? 16 : 3);
    pop_result(data, ok);
    tests_run++;
    if (!ok || data !== exp_a) begin tests_failed++; $display("FAIL len16_pos: got %0d required %0d", $signed(data), $signed(exp_a)); end
    pop_result(data, ok);
    tests_run++;
    if (!ok || data !== exp_b) begin tests_failed++; $display("FAIL len16_neg: got %0d required %0d", $signed(data), $signed(exp_b)); end
  endtask

  task automatic test_len0_and_cfg_change();
    logic [ACC_W-1:0] data;
    bit ok;
    int extra = 0;
    send_beat(5, 5, 0);
    @(posedge clk_i); #1;
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL len0_closed: busy=%0b required 0", busy_o); end
    pop_result(data, ok);
    tests_run++;
    if (!ok || data !== ACC_W'(10)) begin tests_failed++; $display("FAIL len0_result: got %0d required 10", $signed(data)); end
    send_beat(1, 2, 3);
    send_beat(3, 4, 1);
    send_beat(5, 6, 0);
    pop_result(data, ok);
    tests_run++;
    if (!ok || data !== ACC_W'(21)) begin tests_failed++; $display("FAIL cfg_change_result: got %0d required 21", $signed(data)); end
    repeat (6) begin
      @(posedge clk_i); #1;
      if (out_valid_o) extra++;
    end
    tests_run++;
    if (extra != 0) begin tests_failed++; $display("FAIL cfg_change_extra: got %0d extra valid cycles required 0", extra); end
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] data;
    bit ok;
    int ready_cycles = 0;
    int head_bad = 0;
    out_ready_i = 1'b0;
    send_beat(10, 1, 1);
    send_beat(20, 2, 1);
    set_beat(30, 3, 1);
    in_valid_i = 1'b1;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (in_ready_o) ready_cycles++;
      if (out_valid_o && out_data_o !== ACC_W'(11)) head_bad++;
    end
    tests_run++;
    if (ready_cycles != 0) begin tests_failed++; $display("FAIL bp_ready_low: ready seen %0d cycles required 0", ready_cycles); end
    tests_run++;
    if (!out_valid_o || head_bad != 0) begin tests_failed++; $display("FAIL bp_head_stable: valid=%0b unstable=%0d required valid=1 unstable=0", out_valid_o, head_bad); end
    pop_result(data, ok);
    tests_run++;
    if (!ok || data !== ACC_W'(11)) begin tests_failed++; $display("FAIL bp_first: got %0d required 11", $signed(data)); end
    send_beat(30, 3, 1);
    pop_result(data, ok);
    tests_run++;
    if (!ok || data !== ACC_W'(22)) begin tests_failed++; $display("FAIL bp_second: got %0d required 22", $signed(data)); end
    pop_result(data, ok);
    tests_run++;
    if (!ok || data !== ACC_W'(33)) begin tests_failed++; $display("FAIL bp_third: got %0d required 33", $signed(data)); end
    repeat (4) @(posedge clk_i);
    #1;
    tests_run++;
    if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL bp_no_duplicate: valid=%0b required 0", out_valid_o); end
  endtask

  task automatic test_reset_mid_group();
    logic [ACC_W-1:0] data;
    bit ok;
    int valid_cycles = 0;
    send_beat(1, 0, 4);
    send_beat(2, 0, 4);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (out_valid_o) valid_cycles++;
    end
    tests_run++;
    if (valid_cycles != 0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_output: valid cycles=%0d busy=%0b required 0 and 0", valid_cycles, busy_o);
    end
    send_beat(1, 1, 2);
    send_beat(2, 2, 2);
    pop_result(data, ok);
    tests_run++;
    if (!ok || data !== ACC_W'(6)) begin tests_failed++; $display("FAIL rst_mid_next_group: got %0d required 6", $signed(data)); end
  endtask

  task automatic test_random_groups();
    logic [ACC_W-1:0] exp_q [$];
    logic [ACC_W-1:0] exp_v;
    logic [ACC_W-1:0] pdata;
    int groups_sent = 0, popped = 0, outstanding = 0, max_out = 0;
    int beat_idx = 0, eff = 1, sum = 0, p0 = 0, p1 = 0, cycles = 0;
    bit have_beat = 0, acc, popv;
    while (popped < 200 && cycles < 40000) begin
      if (!have_beat && groups_sent < 200) begin
        if (beat_idx == 0) begin
          int len = $urandom_range(0, 16);
          eff = (len == 0) ? 1 : len;
          sum = 0;
          cfg_len_i = len[LEN_W-1:0];
        end else begin
          cfg_len_i = LEN_W'($urandom_range(0, 16));
        end
        p0 = int'($urandom_range(0, 16384)) - 8192;
        p1 = int'($urandom_range(0, 16384)) - 8192;
        in_psum_i[0] = p0[PSUM_W-1:0];
        in_psum_i[1] = p1[PSUM_W-1:0];
        have_beat = 1;
      end
      in_valid_i  = have_beat && ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      acc   = in_valid_i && in_ready_o;
      popv  = out_valid_o && out_ready_i;
      pdata = out_data_o;
      @(posedge clk_i); #1;
      cycles++;
      if (acc) begin
        have_beat = 0;
        sum += p0 + p1;
        beat_idx++;
        if (beat_idx == eff) begin
          exp_q.push_back(ACC_W'(sum));
          beat_idx = 0;
          groups_sent++;
          outstanding++;
        end
      end
      if (popv) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_unexpected_pop: got %0d with no result pending", $signed(pdata));
        end else begin
          exp_v = exp_q.pop_front();
          if (pdata !== exp_v) begin
            tests_failed++;
            $display("FAIL rand_result_%0d: got %0d required %0d", popped, $signed(pdata), $signed(exp_v));
          end
        end
        popped++;
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    tests_run++;
    if (popped != 200) begin tests_failed++; $display("FAIL rand_count: popped %0d required 200", popped); end
    tests_run++;
    if (max_out > 2) begin tests_failed++; $display("FAIL rand_overflow: outstanding peak %0d required <= 2", max_out); end
  endtask

  initial begin
    test_reset();
    test_len1_latency();
    test_len16_back_to_back();
    test_len0_and_cfg_change();
    test_backpressure();
    test_reset_mid_group();
    test_random_groups();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
